// File: rtl/noc_echo_peer.sv
// Loopback endpoint for the packet-sim flit port: buffers inbound packets and
// returns them with the header rewritten to ECHO_DEST, using credit backpressure.
module noc_echo_peer #(
    parameter int                    FLIT_WIDTH   = 32,
    parameter int                    BUFFER_DEPTH = 8,
    parameter logic [FLIT_WIDTH-1:0] ECHO_DEST    = '0,
    parameter int                    COUNT_WIDTH  = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              rx,
    input  logic [FLIT_WIDTH-1:0]             data_i,
    output logic                              credit_o,
    output logic                              tx,
    output logic [FLIT_WIDTH-1:0]             data_o,
    input  logic                              credit_i,
    output logic [$clog2(BUFFER_DEPTH):0]     fifo_level,
    output logic [COUNT_WIDTH-1:0]            rx_pkt_count,
    output logic [COUNT_WIDTH-1:0]            tx_pkt_count,
    output logic                              proto_err
);

    localparam int AW = $clog2(BUFFER_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {R_HEADER, R_SIZE, R_PAYLOAD} rx_state_t;
    typedef enum logic [1:0] {T_HEADER, T_SIZE, T_PAYLOAD} tx_state_t;

    logic [FLIT_WIDTH-1:0] mem [BUFFER_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [LW-1:0]         level_next;
    logic [FLIT_WIDTH-1:0] head;
    logic                  push, pop;

    rx_state_t             rx_state, rx_state_next;
    tx_state_t             tx_state, tx_state_next;
    logic [FLIT_WIDTH-1:0] rcnt, rcnt_next, tcnt, tcnt_next;
    logic                  rx_done, tx_done;

    assign tx   = (fifo_level != '0);
    assign push = rx && credit_o;
    assign pop  = tx && credit_i;
    assign head = mem[rd_ptr];

    // Header slot is replaced on the way out; idle output is forced to zero.
    always_comb begin
        data_o = '0;
        if (tx) data_o = (tx_state == T_HEADER) ? ECHO_DEST : head;
    end

    always_comb begin
        level_next = fifo_level;
        if (push && !pop)      level_next = fifo_level + LW'(1);
        else if (!push && pop) level_next = fifo_level - LW'(1);
    end

    always_comb begin
        rx_state_next = rx_state;
        rcnt_next     = rcnt;
        rx_done       = 1'b0;
        if (push) begin
            case (rx_state)
                R_HEADER: rx_state_next = R_SIZE;
                R_SIZE: begin
                    if (data_i == '0) begin
                        rx_state_next = R_HEADER;
                        rx_done       = 1'b1;
                    end else begin
                        rx_state_next = R_PAYLOAD;
                        rcnt_next     = data_i;
                    end
                end
                R_PAYLOAD: begin
                    rcnt_next = rcnt - FLIT_WIDTH'(1);
                    if (rcnt == FLIT_WIDTH'(1)) begin
                        rx_state_next = R_HEADER;
                        rx_done       = 1'b1;
                    end
                end
                default: rx_state_next = R_HEADER;
            endcase
        end
    end

    always_comb begin
        tx_state_next = tx_state;
        tcnt_next     = tcnt;
        tx_done       = 1'b0;
        if (pop) begin
            case (tx_state)
                T_HEADER: tx_state_next = T_SIZE;
                T_SIZE: begin
                    if (head == '0) begin
                        tx_state_next = T_HEADER;
                        tx_done       = 1'b1;
                    end else begin
                        tx_state_next = T_PAYLOAD;
                        tcnt_next     = head;
                    end
                end
                T_PAYLOAD: begin
                    tcnt_next = tcnt - FLIT_WIDTH'(1);
                    if (tcnt == FLIT_WIDTH'(1)) begin
                        tx_state_next = T_HEADER;
                        tx_done       = 1'b1;
                    end
                end
                default: tx_state_next = T_HEADER;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            credit_o     <= 1'b0;
            rx_state     <= R_HEADER;
            tx_state     <= T_HEADER;
            rcnt         <= '0;
            tcnt         <= '0;
            rx_pkt_count <= '0;
            tx_pkt_count <= '0;
            proto_err    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_level <= level_next;
            credit_o   <= (level_next < LW'(BUFFER_DEPTH));
            rx_state   <= rx_state_next;
            tx_state   <= tx_state_next;
            rcnt       <= rcnt_next;
            tcnt       <= tcnt_next;
            if (rx_done) rx_pkt_count <= rx_pkt_count + COUNT_WIDTH'(1);
            if (tx_done) tx_pkt_count <= tx_pkt_count + COUNT_WIDTH'(1);
            if (rx && !credit_o) proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_noc_echo_peer.sv
// Bench for noc_echo_peer: packet-level queue model checked every cycle, plus
// directed packets whose returned flits are pinned against literal values.
module tb_noc_echo_peer;

    localparam int          FW    = 32;
    localparam int          DEPTH = 8;
    localparam int          CW    = 16;
    localparam logic [31:0] ECHO  = 32'h0000_00E0;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          rx = 1'b0;
    logic [FW-1:0] data_i = '0;
    logic          credit_i = 1'b0;
    logic          credit_o, tx, proto_err;
    logic [FW-1:0] data_o;
    logic [3:0]    fifo_level;
    logic [CW-1:0] rx_pkt_count, tx_pkt_count;

    always #5 clock = ~clock;

    noc_echo_peer #(
        .FLIT_WIDTH  (FW),
        .BUFFER_DEPTH(DEPTH),
        .ECHO_DEST   (ECHO),
        .COUNT_WIDTH (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx          (rx),
        .data_i      (data_i),
        .credit_o    (credit_o),
        .tx          (tx),
        .data_o      (data_o),
        .credit_i    (credit_i),
        .fifo_level  (fifo_level),
        .rx_pkt_count(rx_pkt_count),
        .tx_pkt_count(tx_pkt_count),
        .proto_err   (proto_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of flits as they must leave, tagged with end-of-packet.
    typedef struct {
        logic [31:0] val;
        bit          last;
    } item_t;

    item_t       exp_q[$];
    logic [31:0] obs[$];
    bit          is_hdr = 0, is_last = 0;
    bit          m_credit = 0, m_perr = 0, started = 0;
    bit          m_push, m_pop;
    int          m_level = 0, m_rx = 0, m_tx = 0;
    item_t       m_it;

    always @(posedge clock) begin
        if (!reset) begin
            exp_q.delete();
            m_level  = 0;
            m_rx     = 0;
            m_tx     = 0;
            m_credit = 0;
            m_perr   = 0;
            started  = 1;
        end else begin
            m_push = rx && m_credit;
            m_pop  = (m_level != 0) && credit_i;
            if (rx && !m_credit) m_perr = 1;
            if (m_pop) begin
                m_it = exp_q.pop_front();
                if (m_it.last) m_tx++;
            end
            if (m_push) begin
                m_it.val  = is_hdr ? ECHO : data_i;
                m_it.last = is_last;
                exp_q.push_back(m_it);
                if (is_last) m_rx++;
            end
            m_level  = exp_q.size();
            m_credit = (m_level < DEPTH);
        end
    end

    always @(negedge clock) begin
        if (started) begin
            chk("credit_o", credit_o, m_credit);
            chk("tx", tx, m_level != 0);
            chk("fifo_level", fifo_level, m_level);
            if (m_level != 0) chk("data_o", data_o, exp_q[0].val);
            else              chk("data_o_idle", data_o, 0);
            chk("rx_pkt_count", rx_pkt_count, m_rx[15:0]);
            chk("tx_pkt_count", tx_pkt_count, m_tx[15:0]);
            chk("proto_err", proto_err, m_perr);
            if (tx && credit_i) obs.push_back(data_o);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] v, input bit h, input bit l);
        int guard = 0;
        while (!credit_o && guard <= 200) begin
            tick();
            guard++;
        end
        if (guard > 200) chk("credit_wait", credit_o, 1);
        rx = 1; data_i = v; is_hdr = h; is_last = l;
        tick();
        rx = 0; is_hdr = 0; is_last = 0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while (fifo_level != 0 && g < 300) begin
            tick();
            g++;
        end
        chk("drain_done", fifo_level, 0);
        tick();
    endtask

    task automatic do_reset();
        reset = 0;
        tick();
        tick();
        reset = 1;
        tick();
    endtask

    initial begin
        repeat (3) tick();
        reset = 1;

        // Idle after reset: credit comes up one cycle after release.
        @(negedge clock);
        chk("idle_credit0", credit_o, 0);
        chk("idle_tx", tx, 0);
        chk("idle_level", fifo_level, 0);
        chk("idle_rxcnt", rx_pkt_count, 0);
        chk("idle_txcnt", tx_pkt_count, 0);
        tick();
        @(negedge clock);
        chk("idle_credit1", credit_o, 1);
        tick();

        // Single packet, cut-through with credit_i held high.
        credit_i = 1;
        obs.delete();
        send(32'h11, 1, 0);
        send(32'h2, 0, 0);
        send(32'hA, 0, 0);
        send(32'hB, 0, 1);
        wait_drain();
        chk("p1_n", obs.size(), 4);
        chk("p1_f0", obs[0], ECHO);
        chk("p1_f1", obs[1], 32'h2);
        chk("p1_f2", obs[2], 32'hA);
        chk("p1_f3", obs[3], 32'hB);
        chk("p1_rxcnt", rx_pkt_count, 1);
        chk("p1_txcnt", tx_pkt_count, 1);

        // Backpressure: N=8 packet, FIFO fills after 8 pushes.
        do_reset();
        credit_i = 0;
        obs.delete();
        send(32'h22, 1, 0);
        send(32'h8, 0, 0);
        for (int i = 0; i < 6; i++) send(32'h100 + i, 0, 0);
        @(negedge clock);
        chk("bp_credit_low", credit_o, 0);
        chk("bp_level", fifo_level, 8);
        tick();
        credit_i = 1;
        send(32'h106, 0, 0);
        send(32'h107, 0, 1);
        wait_drain();
        chk("bp_n", obs.size(), 10);
        chk("bp_f0", obs[0], ECHO);
        chk("bp_f1", obs[1], 32'h8);
        for (int i = 0; i < 8; i++) chk("bp_payload", obs[2+i], 32'h100 + i);
        chk("bp_rxcnt", rx_pkt_count, 1);
        chk("bp_txcnt", tx_pkt_count, 1);

        // Zero-size packets back to back.
        do_reset();
        credit_i = 1;
        obs.delete();
        send(32'h5, 1, 0);
        send(32'h0, 0, 1);
        send(32'h6, 1, 0);
        send(32'h0, 0, 1);
        wait_drain();
        chk("z_n", obs.size(), 4);
        chk("z_f0", obs[0], ECHO);
        chk("z_f1", obs[1], 32'h0);
        chk("z_f2", obs[2], ECHO);
        chk("z_f3", obs[3], 32'h0);
        chk("z_rxcnt", rx_pkt_count, 2);
        chk("z_txcnt", tx_pkt_count, 2);

        // Protocol error: push into a full FIFO is dropped and sticks proto_err.
        do_reset();
        credit_i = 0;
        obs.delete();
        send(32'h33, 1, 0);
        send(32'h8, 0, 0);
        for (int i = 0; i < 6; i++) send(32'h200 + i, 0, 0);
        rx = 1; data_i = 32'hDEAD; is_hdr = 0; is_last = 0;
        tick();
        rx = 0;
        @(negedge clock);
        chk("pe_set", proto_err, 1);
        chk("pe_level", fifo_level, 8);
        tick();
        credit_i = 1;
        send(32'h206, 0, 0);
        send(32'h207, 0, 1);
        wait_drain();
        chk("pe_sticky", proto_err, 1);
        chk("pe_n", obs.size(), 10);
        chk("pe_f0", obs[0], ECHO);
        chk("pe_f1", obs[1], 32'h8);
        for (int i = 0; i < 8; i++) chk("pe_payload", obs[2+i], 32'h200 + i);

        // Reset mid-packet discards buffered flits.
        credit_i = 0;
        send(32'h44, 1, 0);
        send(32'h4, 0, 0);
        reset = 0;
        tick();
        @(negedge clock);
        chk("rst_credit", credit_o, 0);
        chk("rst_tx", tx, 0);
        chk("rst_data", data_o, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_rxcnt", rx_pkt_count, 0);
        chk("rst_txcnt", tx_pkt_count, 0);
        chk("rst_perr", proto_err, 0);
        tick();
        reset = 1;
        @(negedge clock);
        chk("rst_tx_after", tx, 0);
        tick();
        credit_i = 1;
        obs.delete();
        send(32'h1, 1, 0);
        send(32'h1, 0, 0);
        send(32'hC, 0, 1);
        wait_drain();
        chk("r_n", obs.size(), 3);
        chk("r_f0", obs[0], ECHO);
        chk("r_f1", obs[1], 32'h1);
        chk("r_f2", obs[2], 32'hC);
        chk("r_rxcnt", rx_pkt_count, 1);
        chk("r_txcnt", tx_pkt_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
